// File: rtl/uart_io_buffer.sv
// Host I/O buffer between uart_rx/uart_tx and the execute stage: RX/TX rings, LOAD sync handshake, IN/OUT requests.
// Optional build macro UART_IO_DROP_CNT_EN enables the saturating dropped-RX-byte counter on drop_cnt.
module uart_io_buffer #(
    parameter int         RX_AW     = 11,
    parameter int         TX_AW     = 11,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        req,
    input  logic        req_dir,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        sync_sent,
    output logic        sync_received,
    output logic        rx_overflow,
    output logic [15:0] drop_cnt
);
    localparam int             RX_N     = 1 << RX_AW;
    localparam int             TX_N     = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_WAITB = 2'd3;
    localparam logic [1:0] T_IDLE = 2'd0, T_READ = 2'd1, T_SEND = 2'd2, T_GAP = 2'd3;
    localparam logic [2:0] R_IDLE = 3'd0, R_IN_RD = 3'd1, R_IN_CAP = 3'd2,
                           R_OUT_WAIT = 3'd3, R_OUT_PUSH = 3'd4, R_DONE = 3'd5;

    // First captured byte clears the upper bytes so short INs come out zero-extended.
    function automatic logic [31:0] merge_byte(input logic [31:0] acc, input logic [1:0] k,
                                               input logic [7:0] b);
        logic [31:0] res;
        res = (k == 2'd0) ? 32'd0 : acc;
        res[{k, 3'b000} +: 8] = b;
        return res;
    endfunction

    logic [7:0]     r_rx_mem [RX_N];
    logic [7:0]     r_tx_mem [TX_N];
    logic [RX_AW:0] r_rx_wr, r_rx_rd;
    logic [TX_AW:0] r_tx_wr, r_tx_rd;
    logic [7:0]     r_rx_q, r_tx_q;
    logic [1:0]     r_s_state, r_t_state, r_k, r_len;
    logic [2:0]     r_req_state;
    logic [31:0]    r_wdata, r_acc, r_rdata;
    logic           r_sync_sent, r_rx_overflow;

    logic [RX_AW:0] w_rx_cnt;
    logic [TX_AW:0] w_tx_cnt, w_tx_free;
    logic           w_rx_full, w_rx_empty, w_rx_push, w_rx_drop, w_rx_pop;
    logic           w_tx_empty, w_tx_push, w_tx_pop, w_out_fits;
    logic [7:0]     w_wbyte;
    logic [31:0]    w_acc_next;

    assign w_rx_cnt   = r_rx_wr - r_rx_rd;
    assign w_rx_full  = (w_rx_cnt == RX_DEPTH);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_push  = (mode == 3'd2) && rx_ready && !w_rx_full;
    assign w_rx_drop  = (mode == 3'd2) && rx_ready && w_rx_full;
    assign w_rx_pop   = (r_req_state == R_IN_RD) && !w_rx_empty;

    assign w_tx_cnt   = r_tx_wr - r_tx_rd;
    assign w_tx_free  = TX_DEPTH - w_tx_cnt;
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_push  = (r_req_state == R_OUT_PUSH);
    assign w_tx_pop   = (r_t_state == T_READ);
    assign w_out_fits = {{(31 - TX_AW){1'b0}}, w_tx_free} >= ({30'd0, r_len} + 32'd1);
    assign w_wbyte    = r_wdata[{r_k, 3'b000} +: 8];
    assign w_acc_next = merge_byte(r_acc, r_k, r_rx_q);

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= rx_data;
        if (w_rx_pop)  r_rx_q <= r_rx_mem[r_rx_rd[RX_AW-1:0]];
        if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= w_wbyte;
        if (w_tx_pop)  r_tx_q <= r_tx_mem[r_tx_rd[TX_AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wr       <= '0;
            r_rx_rd       <= '0;
            r_tx_wr       <= '0;
            r_tx_rd       <= '0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_drop) r_rx_overflow <= 1'b1;
        end
    end

`ifdef UART_IO_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_drop_cnt;
    always_ff @(posedge clk) begin
        if (rst)            r_drop_cnt <= 16'd0;
        else if (w_rx_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

    // Sync and drain share uart_tx; each only starts while the other is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_state   <= S_IDLE;
            r_sync_sent <= 1'b0;
            r_t_state   <= T_IDLE;
        end else begin
            case (r_s_state)
                S_IDLE:  if (mode == 3'd1 && !r_sync_sent && r_t_state == T_IDLE) r_s_state <= S_SEND;
                S_SEND:  r_s_state <= S_GAP;
                S_GAP:   r_s_state <= S_WAITB;
                default: if (!tx_busy) begin
                    r_sync_sent <= 1'b1;
                    r_s_state   <= S_IDLE;
                end
            endcase
            case (r_t_state)
                T_IDLE:  if (mode != 3'd1 && r_s_state == S_IDLE && !w_tx_empty && !tx_busy)
                             r_t_state <= T_READ;
                T_READ:  r_t_state <= T_SEND;
                T_SEND:  r_t_state <= T_GAP;
                default: if (!tx_busy) r_t_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_req_state == R_IDLE && req) begin
            r_len   <= req_len;
            r_wdata <= req_wdata;
        end
        if (r_req_state == R_IN_CAP) r_acc <= w_acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_state <= R_IDLE;
            r_k         <= 2'd0;
            r_rdata     <= 32'd0;
        end else begin
            case (r_req_state)
                R_IDLE: if (req) begin
                    r_k         <= 2'd0;
                    r_req_state <= req_dir ? R_OUT_WAIT : R_IN_RD;
                end
                R_IN_RD:    if (!w_rx_empty) r_req_state <= R_IN_CAP;
                R_IN_CAP: if (r_k == r_len) begin
                    r_rdata     <= w_acc_next;
                    r_req_state <= R_DONE;
                end else begin
                    r_k         <= r_k + 2'd1;
                    r_req_state <= R_IN_RD;
                end
                R_OUT_WAIT: if (w_out_fits) r_req_state <= R_OUT_PUSH;
                R_OUT_PUSH: if (r_k == r_len) r_req_state <= R_DONE;
                            else r_k <= r_k + 2'd1;
                default:    r_req_state <= R_IDLE;
            endcase
        end
    end

    assign busy          = (req && r_req_state == R_IDLE) || (r_req_state != R_IDLE);
    assign done          = (r_req_state == R_DONE);
    assign rdata         = r_rdata;
    assign sync_sent     = r_sync_sent;
    assign rx_overflow   = r_rx_overflow;
    assign sync_received = rx_ready && (rx_data == SYNC_BYTE);
    assign tx_start      = (r_s_state == S_SEND) || (r_t_state == T_SEND);
    assign tx_data       = (r_s_state == S_SEND) ? SYNC_BYTE :
                           (r_t_state == T_SEND) ? r_tx_q : 8'h00;
endmodule

// File: tb/tb_uart_io_buffer.sv
// Directed bench for uart_io_buffer (RX_AW=2, TX_AW=3) with a uart_tx busy model and TX/IN scoreboards.
module tb_uart_io_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        req = 1'b0;
    logic        req_dir = 1'b0;
    logic [1:0]  req_len = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done;
    logic [31:0] rdata;
    logic        sync_sent, sync_received, rx_overflow;
    logic [15:0] drop_cnt;

    int tests = 0, fails = 0;
    int cyc = 0, busy_cnt = 0, tx_cnt = 0, done_cnt = 0, last_tx = -1;
    bit hold_busy = 1'b0;
    logic [7:0]  q_tx[$];
    logic [31:0] q_in[$];

    uart_io_buffer #(.RX_AW(2), .TX_AW(3), .SYNC_BYTE(8'hAA)) dut (
        .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .req(req), .req_dir(req_dir), .req_len(req_len), .req_wdata(req_wdata),
        .busy(busy), .done(done), .rdata(rdata), .sync_sent(sync_sent),
        .sync_received(sync_received), .rx_overflow(rx_overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: busy for 10 cycles after each start pulse
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (tx_start === 1'b1) begin
            tx_cnt++;
            chk("tx_expected", 32'(q_tx.size() != 0), 32'd1);
            if (q_tx.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, q_tx.pop_front()});
            if (last_tx >= 0) chk("tx_gap_ge4", 32'(cyc - last_tx >= 4), 32'd1);
            last_tx = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic do_req(input logic dir, input logic [1:0] len, input logic [31:0] wd);
        req = 1'b1; req_dir = dir; req_len = len; req_wdata = wd;
        #1;
        chk("busy_on_req", {31'd0, busy}, 32'd1);
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(input bit is_in, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            chk("busy_hold", {31'd0, busy}, 32'd1);
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (done === 1'b1) begin
            chk("busy_in_done", {31'd0, busy}, 32'd1);
            if (is_in && q_in.size() != 0) chk("in_rdata", rdata, q_in.pop_front());
            tick();
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dcnt;
        int tcnt;
        logic [15:0] exp_drop;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_sync_sent", {31'd0, sync_sent}, 32'd0);
        chk("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;

        // LOAD sync: single 0xAA pulse, sync_sent once busy falls
        mode = 3'd1;
        q_tx.push_back(8'hAA);
        n = 0;
        while (sync_sent !== 1'b1 && n < 40) begin tick(); n++; end
        chk("sync_sent_set", {31'd0, sync_sent}, 32'd1);
        chk("sync_busy_low", {31'd0, tx_busy}, 32'd0);
        repeat (20) tick();
        chk("sync_one_pulse", tx_cnt, 32'd1);
        chk("sync_q_empty", q_tx.size(), 32'd0);

        // sync_received is combinational; RX in LOAD mode is discarded
        rx_data = 8'hAA; rx_ready = 1'b1;
        #1 chk("sync_rx_hit", {31'd0, sync_received}, 32'd1);
        rx_data = 8'h55;
        #1 chk("sync_rx_miss", {31'd0, sync_received}, 32'd0);
        tick();
        rx_ready = 1'b0;

        // EXEC: 4-byte IN assembled little-endian
        mode = 3'd2;
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h44);
        q_in.push_back(32'h44332211);
        do_req(1'b0, 2'd3, 32'd0);
        wait_done(1'b1, 50);

        // OUT 2 bytes: EF then BE on the wire
        q_tx.push_back(8'hEF);
        q_tx.push_back(8'hBE);
        do_req(1'b1, 2'd1, 32'h1234BEEF);
        wait_done(1'b0, 20);
        n = 0;
        while ((q_tx.size() != 0 || tx_busy) && n < 200) begin tick(); n++; end
        chk("out_drained", q_tx.size(), 32'd0);
        repeat (10) tick();
        chk("out_tx_count", tx_cnt, 32'd3);
        chk("out_ring_empty", {31'd0, dut.w_tx_empty}, 32'd1);

        // RX overflow on a 4-entry ring
        rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
        chk("ovf_not_yet", {31'd0, rx_overflow}, 32'd0);
        rx_byte(8'h05); rx_byte(8'h06);
        chk("ovf_set", {31'd0, rx_overflow}, 32'd1);
`ifdef UART_IO_DROP_CNT_EN
        exp_drop = 16'd2;
`else
        exp_drop = 16'd0;
`endif
        chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drop});
        for (int i = 1; i <= 4; i++) begin
            q_in.push_back(32'(i));
            do_req(1'b0, 2'd0, 32'd0);
            wait_done(1'b1, 50);
        end
        chk("ovf_sticky", {31'd0, rx_overflow}, 32'd1);

        // IN blocks on an empty ring until a byte arrives
        do_req(1'b0, 2'd0, 32'd0);
        dcnt = done_cnt;
        repeat (20) begin
            chk("in_block_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        chk("in_block_no_done", done_cnt, dcnt);
        chk("in_block_rdata_hold", rdata, 32'h00000004);
        q_in.push_back(32'h0000005A);
        rx_byte(8'h5A);
        wait_done(1'b1, 20);

        // Reset in the middle of a 4-byte OUT, after two pushes
        mode = 3'd0;
        hold_busy = 1'b1;
        do_req(1'b1, 2'd3, 32'hCAFEF00D);
        repeat (3) tick();
        dcnt = done_cnt;
        tcnt = tx_cnt;
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_sync_sent", {31'd0, sync_sent}, 32'd0);
        chk("mid_rst_overflow", {31'd0, rx_overflow}, 32'd0);
        chk("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        hold_busy = 1'b0;
        repeat (20) tick();
        chk("mid_rst_no_done", done_cnt, dcnt);
        chk("mid_rst_no_tx", tx_cnt, tcnt);
        chk("mid_rst_ring_empty", {31'd0, dut.w_tx_empty}, 32'd1);
        chk("mid_rst_busy_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
